// File: rtl/v850_pkg.sv
// ---------------------------------------------------------------------------
// v850_pkg : shared types, length decode and reset PC for the V850 IF stage.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package v850_pkg;

  // Encoded value equals the instruction length in halfwords.
  typedef enum logic [1:0] {
    ILEN16 = 2'd1,
    ILEN32 = 2'd2,
    ILEN48 = 2'd3
  } ilen_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  localparam logic [24:0] V850_RESET_PC = 25'h0;

  function automatic ilen_t ilen_decode(input logic [15:0] h);
    logic [5:0] op;
    logic [4:0] r2;
    op = h[10:5];
    r2 = h[15:11];
    if ((op == 6'h31 || op == 6'h17) && r2 == 5'd0) return ILEN48;
    if (op >= 6'h30) return ILEN32;
    return ILEN16;
  endfunction

endpackage

`default_nettype wire

// File: rtl/v850_hw_ring.sv
// ---------------------------------------------------------------------------
// v850_hw_ring : halfword ring, 1/2-halfword write, 0-3 halfword pop, flush.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module v850_hw_ring #(
  parameter int QDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      wr_en_i,
  input  logic                      wr_hi_only_i,
  input  logic [31:0]               wr_data_i,
  input  logic [1:0]                pop_i,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic [47:0]               head_o
);

  localparam int AW = $clog2(QDEPTH);

  logic [15:0]   mem_q [QDEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [AW-1:0] w_wi0;
  logic [AW-1:0] w_wi1;
  logic [AW-1:0] w_ri0;

  assign w_wi0 = wr_ptr_q[AW-1:0];
  assign w_wi1 = w_wi0 + AW'(1);
  assign w_ri0 = rd_ptr_q[AW-1:0];

  // Extra wrap bit lets count reach QDEPTH without ambiguity.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = {mem_q[w_ri0 + AW'(2)], mem_q[w_ri0 + AW'(1)], mem_q[w_ri0]};

  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      if (wr_hi_only_i) begin
        mem_q[w_wi0] <= wr_data_i[31:16];
      end else begin
        mem_q[w_wi0] <= wr_data_i[15:0];
        mem_q[w_wi1] <= wr_data_i[31:16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + (wr_hi_only_i ? (AW+1)'(1) : (AW+1)'(2));
      rd_ptr_q <= rd_ptr_q + (AW+1)'(pop_i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/v850_ifetch_queue.sv
// ---------------------------------------------------------------------------
// v850_ifetch_queue : V850 IF stage - word fetch, prefetch ring, IF->ID reg.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module v850_ifetch_queue
  import v850_pkg::*;
#(
  parameter int          QDEPTH   = 8,
  parameter logic [24:0] RESET_PC = V850_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [23:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [24:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [63:0] instruction_o,
  output logic [24:0] PC_o
);

  localparam int          AW       = $clog2(QDEPTH);
  localparam logic [AW:0] FILL_MAX = (AW+1)'(QDEPTH - 2);

  fetch_state_t state_q;
  logic         req_q;
  logic [23:0]  addr_q;
  logic [23:0]  fetch_addr_q;
  logic         skip_lo_q;
  logic [24:0]  head_pc_q;
  logic         valid_q;
  logic [63:0]  instr_q;
  logic [24:0]  pc_q;

  logic [AW:0]  count;
  logic [47:0]  head;
  ilen_t        len;
  logic [1:0]   len_hw;
  logic         load;
  logic         wr_en;
  logic [1:0]   pop;
  logic [AW:0]  count_after;
  logic [63:0]  instr_d;

  assign len    = ilen_decode(head[15:0]);
  assign len_hw = len;
  assign load   = (!valid_q || instr_ready_i) && (count >= (AW+1)'(len_hw)) && !redirect_i;
  assign wr_en  = (state_q == F_REQ) && imem_ack_i && !redirect_i;
  assign pop    = load ? len_hw : 2'd0;
  assign count_after = count + (skip_lo_q ? (AW+1)'(1) : (AW+1)'(2)) - (AW+1)'(pop);

  v850_hw_ring #(.QDEPTH(QDEPTH)) u_ring (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_i),
    .wr_en_i      (wr_en),
    .wr_hi_only_i (skip_lo_q),
    .wr_data_i    (imem_rdata_i),
    .pop_i        (pop),
    .count_o      (count),
    .head_o       (head)
  );

  always_comb begin
    instr_d = {48'b0, head[15:0]};
    case (len)
      ILEN32:  instr_d = {32'b0, head[31:0]};
      ILEN48:  instr_d = {16'b0, head[47:0]};
      default: instr_d = {48'b0, head[15:0]};
    endcase
  end

  // addr_q is what memory sees; fetch_addr_q diverges from it only in DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= F_IDLE;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC[24:1];
      fetch_addr_q <= RESET_PC[24:1];
      skip_lo_q    <= RESET_PC[0];
    end else if (redirect_i) begin
      fetch_addr_q <= redirect_pc_i[24:1];
      skip_lo_q    <= redirect_pc_i[0];
      req_q        <= 1'b1;
      if (state_q == F_IDLE || imem_ack_i) begin
        state_q <= F_REQ;
        addr_q  <= redirect_pc_i[24:1];
      end else begin
        state_q <= F_DROP;
      end
    end else begin
      case (state_q)
        F_IDLE: begin
          if (count <= FILL_MAX) begin
            state_q <= F_REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_addr_q;
          end
        end
        F_REQ: begin
          if (imem_ack_i) begin
            fetch_addr_q <= fetch_addr_q + 24'd1;
            addr_q       <= fetch_addr_q + 24'd1;
            skip_lo_q    <= 1'b0;
            if (count_after > FILL_MAX) begin
              state_q <= F_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        F_DROP: begin
          if (imem_ack_i) begin
            state_q <= F_REQ;
            addr_q  <= fetch_addr_q;
          end
        end
        default: begin
          state_q <= F_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= RESET_PC;
      head_pc_q <= RESET_PC;
    end else if (redirect_i) begin
      valid_q   <= 1'b0;
      head_pc_q <= redirect_pc_i;
    end else if (load) begin
      valid_q   <= 1'b1;
      instr_q   <= instr_d;
      pc_q      <= head_pc_q;
      head_pc_q <= head_pc_q + {23'b0, len_hw};
    end else if (instr_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instruction_o = instr_q;
  assign PC_o          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_v850_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_v850_ifetch_queue : random + directed bench with an instruction-stream model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_v850_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [23:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [24:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [63:0] instruction_o;
  logic [24:0] PC_o;

  v850_ifetch_queue #(.QDEPTH(8), .RESET_PC(25'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instruction_o (instruction_o),
    .PC_o          (PC_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_w [256];
  logic [24:0] exp_pc = '0;
  int n_chk = 0, n_pass = 0;
  int mem_mode = 0, ready_mode = 0, edge_n = 0;
  int first_ack = -1, first_valid = -1;
  bit rand_redir = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] hw_at(input logic [24:0] pc);
    logic [31:0] w;
    w = mem_w[pc[8:1]];
    return pc[0] ? w[31:16] : w[15:0];
  endfunction

  function automatic int hw_len(input logic [15:0] h);
    int op, r2;
    op = int'(h[10:5]);
    r2 = int'(h[15:11]);
    if ((op == 49 || op == 23) && r2 == 0) return 3;
    if (op >= 48) return 2;
    return 1;
  endfunction

  function automatic logic [63:0] instr_at(input logic [24:0] pc);
    logic [63:0] r;
    int n;
    r = '0;
    n = hw_len(hw_at(pc));
    for (int i = 0; i < n; i++) r[16*i +: 16] = hw_at(pc + 25'(i));
    return r;
  endfunction

  // One clock: commit this cycle's handshake against the model, then drive the next cycle.
  task automatic tick();
    logic hs, red, ackd;
    logic [24:0] rpc, opc;
    logic [63:0] oins;
    hs   = instr_valid_o && instr_ready_i && !rst;
    red  = redirect_i && !rst;
    ackd = imem_req_o && imem_ack_i && !rst;
    rpc  = redirect_pc_i;
    opc  = PC_o;
    oins = instruction_o;
    @(posedge clk);
    #1;
    edge_n++;
    if (hs) begin
      chk("sb_pc", 64'(opc), 64'(exp_pc));
      chk("sb_instr", oins, instr_at(exp_pc));
      exp_pc = exp_pc + 25'(hw_len(hw_at(exp_pc)));
    end
    if (red) exp_pc = rpc;
    if (ackd && first_ack < 0) first_ack = edge_n;
    if (instr_valid_o && first_valid < 0) first_valid = edge_n;
    redirect_i = 1'b0;
    if (rand_redir && $urandom_range(0, 49) == 0) begin
      redirect_i    = 1'b1;
      redirect_pc_i = 25'($urandom_range(0, 700));
    end
    case (mem_mode)
      0:       imem_ack_i = imem_req_o;
      1:       imem_ack_i = imem_req_o && ($urandom_range(0, 2) == 0);
      default: imem_ack_i = 1'b0;
    endcase
    imem_rdata_i = mem_w[imem_addr_o[7:0]];
    case (ready_mode)
      0:       instr_ready_i = 1'b1;
      1:       instr_ready_i = ($urandom_range(0, 3) != 0);
      default: instr_ready_i = 1'b0;
    endcase
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !instr_valid_o; i++) tick();
    chk(tag, 64'(instr_valid_o), 64'd1);
  endtask

  task automatic reset_on();
    rst = 1'b1;
    redirect_i = 1'b0;
    imem_ack_i = 1'b0;
    exp_pc = 25'h0;
    first_ack = -1;
    first_valid = -1;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_w[i] = $urandom;

    // Reset values and first-instruction latency
    mem_w[0] = 32'h1234_0000;
    mem_w[1] = 32'h0008_0780;
    reset_on();
    chk("rst_req",   64'(imem_req_o),    64'd0);
    chk("rst_addr",  64'(imem_addr_o),   64'd0);
    chk("rst_valid", 64'(instr_valid_o), 64'd0);
    chk("rst_instr", instruction_o,      64'd0);
    chk("rst_pc",    64'(PC_o),          64'd0);
    rst = 1'b0;
    tick();
    chk("req_after_idle", 64'(imem_req_o), 64'd1);
    wait_valid("A_valid0");
    chk("ack_to_valid", 64'(first_valid - first_ack), 64'd1);
    chk("A_pc0", 64'(PC_o), 64'd0);
    chk("A_ins0", instruction_o, 64'h0);
    tick();
    wait_valid("A_valid1");
    chk("A_pc1", 64'(PC_o), 64'd1);
    chk("A_ins1", instruction_o, 64'h1234);
    tick();
    wait_valid("A_valid2");
    chk("A_pc2", 64'(PC_o), 64'd2);
    chk("A_ins2", instruction_o, 64'h0000_0000_0008_0780);
    tick();
    wait_valid("A_valid3");
    chk("A_pc3", 64'(PC_o), 64'd4);

    // Backpressure fills the ring and stops fetching
    for (int i = 0; i < 4; i++) tick();
    ready_mode = 2;
    instr_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("bp_req_off", 64'(imem_req_o), 64'd0);
    chk("bp_valid",   64'(instr_valid_o), 64'd1);
    chk("bp_pc_hold", 64'(PC_o), 64'(exp_pc));
    chk("bp_ins_hold", instruction_o, instr_at(exp_pc));
    ready_mode = 0;
    for (int i = 0; i < 20; i++) tick();

    // Random traffic, wait states, backpressure and redirects
    ready_mode = 1;
    mem_mode   = 1;
    rand_redir = 1;
    for (int i = 0; i < 3000; i++) tick();
    rand_redir = 0;
    ready_mode = 0;
    mem_mode   = 0;

    // 48-bit instruction
    reset_on();
    mem_w[0] = 32'h5678_0620;
    mem_w[1] = 32'h0000_1234;
    rst = 1'b0;
    wait_valid("L48_valid");
    chk("L48_pc", 64'(PC_o), 64'd0);
    chk("L48_ins", instruction_o, 64'h0000_1234_5678_0620);
    tick();
    wait_valid("L48_valid_next");
    chk("L48_next_pc", 64'(PC_o), 64'd3);

    // Redirect to an odd PC while a request is outstanding
    reset_on();
    mem_mode = 2;
    rst = 1'b0;
    for (int i = 0; i < 10 && !imem_req_o; i++) tick();
    redirect_i = 1'b1;
    redirect_pc_i = 25'h3;
    tick();
    chk("drop_valid", 64'(instr_valid_o), 64'd0);
    chk("drop_req",   64'(imem_req_o),    64'd1);
    chk("drop_addr",  64'(imem_addr_o),   64'd0);
    imem_ack_i = 1'b1;
    mem_mode = 0;
    tick();
    chk("redir_req",  64'(imem_req_o),  64'd1);
    chk("redir_addr", 64'(imem_addr_o), 64'd1);
    wait_valid("redir_valid");
    chk("redir_pc",  64'(PC_o), 64'd3);
    chk("redir_ins", instruction_o, instr_at(25'h3));
    for (int i = 0; i < 10; i++) tick();

    // Asynchronous reset in the middle of a stalled request
    mem_mode = 2;
    for (int i = 0; i < 20 && !imem_req_o; i++) tick();
    chk("mid_req_pending", 64'(imem_req_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   64'(imem_req_o),    64'd0);
    chk("arst_addr",  64'(imem_addr_o),   64'd0);
    chk("arst_valid", 64'(instr_valid_o), 64'd0);
    chk("arst_instr", instruction_o,      64'd0);
    chk("arst_pc",    64'(PC_o),          64'd0);
    exp_pc = 25'h0;
    redirect_i = 1'b0;
    tick();
    rst = 1'b0;
    mem_mode = 0;
    imem_ack_i = 1'b1;
    tick();
    chk("restart_req",  64'(imem_req_o),  64'd1);
    chk("restart_addr", 64'(imem_addr_o), 64'd0);
    wait_valid("restart_valid");
    chk("restart_pc",  64'(PC_o), 64'd0);
    chk("restart_ins", instruction_o, instr_at(25'h0));
    for (int i = 0; i < 20; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
